// File: rtl/riscv_div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Each iteration subtracts the divisor magnitude through a Brent-Kung adder.
module bk_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   sum
);
    localparam int L = $clog2(N);

    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;

    // In-place Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the rest
    always_comb begin
        g_s = a & b;
        p_s = a ^ b;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (2 ** (k + 1))) == 0) begin
                    g_s[i] = g_s[i] | (p_s[i] & g_s[i - 2 ** k]);
                    p_s[i] = p_s[i] & p_s[i - 2 ** k];
                end else begin
                    g_s[i] = g_s[i];
                    p_s[i] = p_s[i];
                end
            end
        end
        for (int d = 0; d < L - 1; d++) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (2 ** (L - 1 - d))) == (2 ** (L - 2 - d))) && (i >= (2 ** (L - 1 - d)))) begin
                    g_s[i] = g_s[i] | (p_s[i] & g_s[i - 2 ** (L - 2 - d)]);
                    p_s[i] = p_s[i] & p_s[i - 2 ** (L - 2 - d)];
                end else begin
                    g_s[i] = g_s[i];
                    p_s[i] = p_s[i];
                end
            end
        end
        c_s[0] = cin;
        for (int i = 0; i < N; i++) begin
            c_s[i + 1] = g_s[i] | (p_s[i] & cin);
        end
    end

    assign sum = {c_s[N], (a ^ b) ^ c_s[N-1:0]};
endmodule

module riscv_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t          state_r, state_s;
    logic [1:0]      op_r;
    logic [XLEN-1:0] rem_r, quo_r, dvsr_r, result_r;
    logic [CW-1:0]   cnt_r;
    logic            q_neg_r, r_neg_r, busy_r, done_r;

    logic            sgn_s, dvd_neg_s, dvs_neg_s, div_zero_s, ovf_s, accept_s, take_s;
    logic [XLEN-1:0] dvd_mag_s, dvs_mag_s, rem_sh_s, fix_val_s;
    logic [XLEN:0]   diff_s;

    assign sgn_s      = ~op[0];
    assign dvd_neg_s  = sgn_s & dividend[XLEN-1];
    assign dvs_neg_s  = sgn_s & divisor[XLEN-1];
    assign dvd_mag_s  = dvd_neg_s ? negate(dividend) : dividend;
    assign dvs_mag_s  = dvs_neg_s ? negate(divisor) : divisor;
    assign div_zero_s = (divisor == ZERO);
    assign ovf_s      = sgn_s & (dividend == MIN_NEG) & (divisor == ALL_ONES);
    assign accept_s   = (state_r == IDLE) & start & ~kill;

    // Trial subtraction: shifted remainder + ~divisor + 1; the shifted-out bit covers the 33rd bit
    assign rem_sh_s = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    bk_adder #(.N(XLEN)) u_sub (
        .a   (rem_sh_s),
        .b   (~dvsr_r),
        .cin (1'b1),
        .sum (diff_s)
    );
    assign take_s    = diff_s[XLEN] | rem_r[XLEN-1];
    assign fix_val_s = op_r[1] ? (r_neg_r ? negate(rem_r) : rem_r)
                               : (q_neg_r ? negate(quo_r) : quo_r);

    // Next-state logic; kill outranks both start and iteration progress
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = (div_zero_s || ovf_s) ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (kill) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 2'b00;
            rem_r    <= ZERO;
            quo_r    <= ZERO;
            dvsr_r   <= ZERO;
            result_r <= ZERO;
            cnt_r    <= {CW{1'b0}};
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        cnt_r <= {CW{1'b0}};
                        if (div_zero_s) begin
                            quo_r   <= ALL_ONES;
                            rem_r   <= dividend;
                            q_neg_r <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (ovf_s) begin
                            quo_r   <= MIN_NEG;
                            rem_r   <= ZERO;
                            q_neg_r <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            quo_r   <= dvd_mag_s;
                            rem_r   <= ZERO;
                            dvsr_r  <= dvs_mag_s;
                            q_neg_r <= dvd_neg_s ^ dvs_neg_s;
                            r_neg_r <= dvd_neg_s;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        rem_r <= take_s ? diff_s[XLEN-1:0] : rem_sh_s;
                        quo_r <= {quo_r[XLEN-2:0], take_s};
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (!kill) begin
                        result_r <= fix_val_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
endmodule

// File: tb/tb_riscv_div_seq.sv
// Directed bench for riscv_div_seq: hand-computed vectors, control corner cases,
// and a corner/random sweep against an RV32M reference model.
module tb_riscv_div_seq;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic        clk, rst_n, start, kill, busy, done;
    logic [1:0]  op;
    logic [31:0] dividend, divisor, result;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    riscv_div_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!o[0]) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input logic [31:0] exp);
        wait_done();
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp);
        issue(o, a, b);
        finish_op(tag, exp_lat, exp);
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [31:0] a, b;
        logic [1:0]  o;
        int          dc;
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd14);
        run("remu_100_7", REMU, 32'd100, 32'd7, 33, 32'd2);
        run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
        run("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
        run("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF);

        run("divu_5_0", DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run("rem_5_0", REM, 32'd5, 32'd0, 1, 32'd5);
        run("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF);
        run("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        run("divu_min_m1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

        // start while busy, and start during the done cycle, are both dropped
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; lat++; end
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        wait_done();
        check("busy_start_latency", 32'(lat), 32'd33);
        check("busy_start_result", result, 32'd14);
        start = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_busy", {31'd0, busy}, 32'd0);
        check("start_in_done_done", {31'd0, done}, 32'd0);
        run("divu_9_3", DIVU, 32'd9, 32'd3, 33, 32'd3);

        // kill during CALC
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_calc_busy", {31'd0, busy}, 32'd0);
        check("kill_calc_done", {31'd0, done}, 32'd0);
        check("kill_calc_result", result, 32'd3);
        dc = 0;
        repeat (40) begin @(posedge clk); #1; if (done) dc++; end
        check("kill_calc_no_done", 32'(dc), 32'd0);

        // kill in IDLE beats start
        start = 1'b1; kill = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_busy", {31'd0, busy}, 32'd0);

        // kill during DONE still delivers the pulse
        issue(DIVU, 32'd5, 32'd0);
        @(posedge clk); #1;
        kill = 1'b1;
        #1;
        check("kill_done_pulse", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_after", {31'd0, done}, 32'd0);
        check("kill_done_result", result, 32'hFFFF_FFFF);

        // kill during FIX leaves result untouched
        issue(REMU, 32'd5, 32'd0);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_fix_busy", {31'd0, busy}, 32'd0);
        check("kill_fix_done", {31'd0, done}, 32'd0);
        check("kill_fix_result", result, 32'hFFFF_FFFF);

        // synchronous reset mid-operation
        issue(DIVU, 32'd100, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int oi = 0; oi < 4; oi++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    o = 2'(oi); a = corners[i]; b = corners[j];
                    run("sweep_corner", o, a, b,
                        (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33,
                        ref_div(o, a, b));
                end
            end
        end
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run("sweep_random", o, a, b, (b == 32'd0) ? 1 : 33, ref_div(o, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
